// File: rtl/fir_coeff_loader.sv
// Double-buffered FIR coefficient loader: words stream into a shadow bank, then commit atomically.
// Optional checksum word and CHECK state enabled by defining FIR_COEFF_CHECKSUM_EN.
`timescale 1ns/1ps
module fir_coeff_loader #(
    parameter int C_W   = 12,
    parameter int C_NUM = 31
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load_start,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [C_W-1:0]         s_data,
    input  logic                   s_last,
    output logic [C_NUM*C_W-1:0]   coeff_out,
    output logic                   coeff_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam int IDX_W = $clog2(C_NUM + 1);
`ifdef FIR_COEFF_CHECKSUM_EN
    localparam int LAST_I = C_NUM;
`else
    localparam int LAST_I = C_NUM - 1;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST_I);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
`ifdef FIR_COEFF_CHECKSUM_EN
        CHECK  = 2'd3,
`endif
        COMMIT = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [C_NUM-1:0][C_W-1:0]    shadow_q, shadow_d;
    logic [C_NUM-1:0][C_W-1:0]    coeff_out_q, coeff_out_d;
    logic                         coeff_valid_q, coeff_valid_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;
    logic                         xfer;
`ifdef FIR_COEFF_CHECKSUM_EN
    logic [C_W-1:0]               sum_q, sum_d;
    logic [C_W-1:0]               csum_q, csum_d;
`endif

    assign s_ready     = (state_q == LOAD);
    assign busy        = (state_q != IDLE);
    assign coeff_out   = coeff_out_q;
    assign coeff_valid = coeff_valid_q;
    assign done        = done_q;
    assign err         = err_q;
    assign xfer        = s_valid && s_ready;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        coeff_out_d   = coeff_out_q;
        coeff_valid_d = coeff_valid_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
`ifdef FIR_COEFF_CHECKSUM_EN
        sum_d         = sum_q;
        csum_d        = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    idx_d   = '0;
`ifdef FIR_COEFF_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            LOAD: begin
                // A restart wins over any word presented in the same cycle.
                if (load_start) begin
                    idx_d = '0;
`ifdef FIR_COEFF_CHECKSUM_EN
                    sum_d = '0;
`endif
                end else if (xfer) begin
                    for (int i = 0; i < C_NUM; i++) begin
                        if (idx_q == IDX_W'(i)) shadow_d[i] = s_data;
                    end
`ifdef FIR_COEFF_CHECKSUM_EN
                    if (idx_q < IDX_W'(C_NUM)) sum_d = sum_q + s_data;
                    csum_d = s_data;
`endif
                    if (idx_q == LAST_IDX) begin
                        if (s_last) begin
`ifdef FIR_COEFF_CHECKSUM_EN
                            state_d = CHECK;
`else
                            state_d = COMMIT;
`endif
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (s_last) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef FIR_COEFF_CHECKSUM_EN
            CHECK: begin
                if (sum_q == csum_q) begin
                    state_d = COMMIT;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            COMMIT: begin
                coeff_out_d   = shadow_q;
                coeff_valid_d = 1'b1;
                done_d        = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            coeff_out_q   <= '0;
            coeff_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            coeff_out_q   <= coeff_out_d;
            coeff_valid_q <= coeff_valid_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    // Shadow contents are meaningless outside a load, so they carry no reset.
    always_ff @(posedge clock) begin
        shadow_q <= shadow_d;
`ifdef FIR_COEFF_CHECKSUM_EN
        sum_q    <= sum_d;
        csum_q   <= csum_d;
`endif
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: commit, backpressure/restart, aborts, async reset, checksum.
`timescale 1ns/1ps
module tb_fir_coeff_loader;
    localparam int C_W   = 12;
    localparam int C_NUM = 31;
    localparam int VW    = C_NUM * C_W;
`ifdef FIR_COEFF_CHECKSUM_EN
    localparam int NW = C_NUM + 1;
`else
    localparam int NW = C_NUM;
`endif

    logic            clock, reset, load_start, s_valid, s_ready, s_last;
    logic [C_W-1:0]  s_data;
    logic [VW-1:0]   coeff_out;
    logic            coeff_valid, busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int err_before;
    logic [VW-1:0] exp1, exp2, exp5;

    fir_coeff_loader #(.C_W(C_W), .C_NUM(C_NUM)) dut (
        .clock(clock), .reset(reset), .load_start(load_start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .coeff_out(coeff_out), .coeff_valid(coeff_valid),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (err === 1'b1) err_cnt++;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic start_load();
        @(negedge clock);
        load_start = 1'b1;
        s_valid    = 1'b0;
        s_last     = 1'b0;
    endtask

    task automatic send(input logic [C_W-1:0] d, input logic l);
        @(negedge clock);
        load_start = 1'b0;
        s_valid    = 1'b1;
        s_data     = d;
        s_last     = l;
    endtask

    task automatic idle();
        @(negedge clock);
        load_start = 1'b0;
        s_valid    = 1'b0;
        s_last     = 1'b0;
    endtask

    // Sends every tap of v (plus checksum when enabled) with s_last on the final word.
    task automatic send_set(input logic [VW-1:0] v);
        logic [C_W-1:0] cs;
        cs = '0;
        for (int i = 0; i < C_NUM; i++) begin
            cs = cs + v[i*C_W +: C_W];
            send(v[i*C_W +: C_W], (i == C_NUM - 1) && (NW == C_NUM));
        end
`ifdef FIR_COEFF_CHECKSUM_EN
        send(cs, 1'b1);
`endif
    endtask

    task automatic finish_commit(input string tag, input logic [VW-1:0] newv,
                                 input logic [VW-1:0] oldv, input logic oldvalid);
        idle();
        chk({tag, "_hold_out"}, coeff_out, oldv);
        chk({tag, "_hold_valid"}, {{(VW-1){1'b0}}, coeff_valid}, {{(VW-1){1'b0}}, oldvalid});
`ifdef FIR_COEFF_CHECKSUM_EN
        @(posedge clock);
`endif
        @(posedge clock);
        #1;
        chk({tag, "_out"}, coeff_out, newv);
        chk({tag, "_valid"}, {{(VW-1){1'b0}}, coeff_valid}, 1);
        chk({tag, "_done"}, {{(VW-1){1'b0}}, done}, 1);
        @(posedge clock);
        #1;
        chk({tag, "_done_off"}, {{(VW-1){1'b0}}, done}, 0);
        chk({tag, "_idle"}, {{(VW-1){1'b0}}, busy}, 0);
    endtask

    initial begin
        clock = 1'b0; reset = 1'b0; load_start = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        for (int i = 0; i < C_NUM; i++) begin
            exp1[i*C_W +: C_W] = C_W'(i + 1);
            exp2[i*C_W +: C_W] = 12'hFFF;
            exp5[i*C_W +: C_W] = (i % 2 == 0) ? 12'h800 : 12'h7FF;
        end

        // Reset state, including across clock edges while held.
        #1;
        chk("rst_out", coeff_out, 0);
        chk("rst_valid", {{(VW-1){1'b0}}, coeff_valid}, 0);
        chk("rst_ready", {{(VW-1){1'b0}}, s_ready}, 0);
        chk("rst_done", {{(VW-1){1'b0}}, done}, 0);
        chk("rst_err", {{(VW-1){1'b0}}, err}, 0);
        load_start = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", {{(VW-1){1'b0}}, busy}, 0);
        @(negedge clock);
        load_start = 1'b0;
        reset = 1'b1;

        // Basic load of 1..31.
        start_load();
        @(posedge clock);
        #1;
        chk("t1_busy", {{(VW-1){1'b0}}, busy}, 1);
        chk("t1_ready", {{(VW-1){1'b0}}, s_ready}, 1);
        send_set(exp1);
        finish_commit("t1", exp1, '0, 1'b0);

        // Backpressure, then restart with a conflicting word, then all 0xFFF.
        err_before = err_cnt;
        start_load();
        for (int k = 0; k < 10; k++) begin
            send(C_W'(12'h200 + k), 1'b0);
            idle();
        end
        chk("t2_midload_out", coeff_out, exp1);
        @(negedge clock);
        load_start = 1'b1;
        s_valid    = 1'b1;
        s_data     = 12'h123;
        s_last     = 1'b1;
        send_set(exp2);
        finish_commit("t2", exp2, exp1, 1'b1);
        chk("t2_no_err", VW'(err_cnt), VW'(err_before));

        // Early s_last on the 5th word.
        start_load();
        for (int k = 0; k < 4; k++) send(C_W'(12'h100 + k), 1'b0);
        send(12'h104, 1'b1);
        idle();
        chk("t3_err", {{(VW-1){1'b0}}, err}, 1);
        chk("t3_idle", {{(VW-1){1'b0}}, busy}, 0);
        chk("t3_keep_out", coeff_out, exp2);
        chk("t3_keep_valid", {{(VW-1){1'b0}}, coeff_valid}, 1);
        chk("t3_no_done", {{(VW-1){1'b0}}, done}, 0);
        idle();
        chk("t3_err_pulse", {{(VW-1){1'b0}}, err}, 0);

        // Missing s_last on the final word.
        start_load();
        for (int k = 0; k < NW; k++) send(C_W'(12'h300 + k), 1'b0);
        idle();
        chk("t3b_err", {{(VW-1){1'b0}}, err}, 1);
        chk("t3b_idle", {{(VW-1){1'b0}}, busy}, 0);
        chk("t3b_keep_out", coeff_out, exp2);

        // Asynchronous reset mid-load.
        start_load();
        for (int k = 0; k < 20; k++) send(C_W'(12'h400 + k), 1'b0);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("t4_out", coeff_out, 0);
        chk("t4_valid", {{(VW-1){1'b0}}, coeff_valid}, 0);
        chk("t4_busy", {{(VW-1){1'b0}}, busy}, 0);
        chk("t4_ready", {{(VW-1){1'b0}}, s_ready}, 0);
        @(negedge clock);
        s_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("t4_post_idle", {{(VW-1){1'b0}}, busy}, 0);

        // Bit-exact extremes after reset.
        start_load();
        send_set(exp5);
        finish_commit("t5", exp5, '0, 1'b0);

`ifdef FIR_COEFF_CHECKSUM_EN
        // Good checksum 0x1F0 commits; 0x1F1 aborts with no commit.
        start_load();
        for (int i = 0; i < C_NUM; i++) send(C_W'(i + 1), 1'b0);
        send(12'h1F0, 1'b1);
        finish_commit("t6_good", exp1, exp5, 1'b1);
        start_load();
        for (int i = 0; i < C_NUM; i++) send(C_W'(i + 1), 1'b0);
        send(12'h1F1, 1'b1);
        idle();
        @(posedge clock);
        #1;
        chk("t6_bad_err", {{(VW-1){1'b0}}, err}, 1);
        chk("t6_bad_no_done", {{(VW-1){1'b0}}, done}, 0);
        @(posedge clock);
        #1;
        chk("t6_bad_keep_out", coeff_out, exp1);
        chk("t6_bad_idle", {{(VW-1){1'b0}}, busy}, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
